// File: rtl/clkdiv_rst_seq.sv
// Clock-divider reset / calibration sequencer.
// Holds the divider in reset until the PLL is locked for HOLD_CYCLES, lets the
// divided clock settle for SETTLE_CYCLES, then reports div_ready. Optional
// calibration pulses (CALIB_WIDTH wide) are enabled by defining the macro
// CLKDIV_RST_SEQ_CALIB_EN; without it calib_req is ignored and the calibration
// outputs are tied low. Any loss of lock returns the sequencer to HOLD.
module clkdiv_rst_seq #(
    parameter int unsigned HOLD_CYCLES   = 16,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned CALIB_WIDTH   = 2
) (
    input  logic hclkin,
    input  logic reset,
    input  logic pll_lock,
    input  logic calib_req,
    output logic div_resetn,
    output logic div_calib,
    output logic div_ready,
    output logic calib_busy,
    output logic calib_done
);

    // One counter shared by every timed state, sized for the longest interval.
    localparam int unsigned CntMax =
        (HOLD_CYCLES > SETTLE_CYCLES) ?
            ((HOLD_CYCLES > CALIB_WIDTH) ? HOLD_CYCLES : CALIB_WIDTH) :
            ((SETTLE_CYCLES > CALIB_WIDTH) ? SETTLE_CYCLES : CALIB_WIDTH);
    localparam int unsigned CntW = (CntMax > 1) ? $clog2(CntMax) : 1;

`ifdef CLKDIV_RST_SEQ_CALIB_EN
    typedef enum logic [2:0] {
        StHold, StSettle, StReady, StCalib, StCalibSettle
    } state_e;
`else
    typedef enum logic [1:0] {
        StHold, StSettle, StReady
    } state_e;
`endif

    logic            lock_meta_q, lock_s_q;
    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            div_resetn_q, div_resetn_d;
    logic            div_ready_q, div_ready_d;

    // Two-flop synchronizer for the asynchronous lock indication.
    always_ff @(posedge hclkin or posedge reset) begin
        if (reset) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
        end
    end

    // State and shared counter registers.
    always_ff @(posedge hclkin or posedge reset) begin
        if (reset) begin
            state_q <= StHold;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; lock loss overrides everything, including calib_req.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!lock_s_q) begin
            // Also restarts (rather than freezes) the HOLD count.
            state_d = StHold;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StHold: begin
                    if (cnt_q == CntW'(HOLD_CYCLES - 1)) begin
                        state_d = StSettle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StSettle: begin
                    if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
                        state_d = StReady;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StReady: begin
`ifdef CLKDIV_RST_SEQ_CALIB_EN
                    if (calib_req) begin
                        state_d = StCalib;
                        cnt_d   = '0;
                    end
`endif
                end
`ifdef CLKDIV_RST_SEQ_CALIB_EN
                StCalib: begin
                    if (cnt_q == CntW'(CALIB_WIDTH - 1)) begin
                        state_d = StCalibSettle;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                StCalibSettle: begin
                    if (cnt_q == CntW'(SETTLE_CYCLES - 1)) begin
                        state_d = StReady;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
`endif
                default: begin
                    state_d = StHold;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Output decode from the next state so the registered outputs track state_q.
    always_comb begin
        div_resetn_d = (state_d != StHold);
        div_ready_d  = (state_d == StReady);
    end

    // Output registers for the always-present outputs.
    always_ff @(posedge hclkin or posedge reset) begin
        if (reset) begin
            div_resetn_q <= 1'b0;
            div_ready_q  <= 1'b0;
        end else begin
            div_resetn_q <= div_resetn_d;
            div_ready_q  <= div_ready_d;
        end
    end

    assign div_resetn = div_resetn_q;
    assign div_ready  = div_ready_q;

`ifdef CLKDIV_RST_SEQ_CALIB_EN
    logic div_calib_q, div_calib_d;
    logic calib_busy_q, calib_busy_d;
    logic calib_done_q, calib_done_d;

    // Calibration output decode; done only on a genuine settle-to-ready exit.
    always_comb begin
        div_calib_d  = (state_d == StCalib);
        calib_busy_d = (state_d == StCalib) || (state_d == StCalibSettle);
        calib_done_d = (state_q == StCalibSettle) && (state_d == StReady);
    end

    // Calibration output registers.
    always_ff @(posedge hclkin or posedge reset) begin
        if (reset) begin
            div_calib_q  <= 1'b0;
            calib_busy_q <= 1'b0;
            calib_done_q <= 1'b0;
        end else begin
            div_calib_q  <= div_calib_d;
            calib_busy_q <= calib_busy_d;
            calib_done_q <= calib_done_d;
        end
    end

    assign div_calib  = div_calib_q;
    assign calib_busy = calib_busy_q;
    assign calib_done = calib_done_q;
`else
    logic unused_calib_req;
    assign unused_calib_req = calib_req;
    assign div_calib  = 1'b0;
    assign calib_busy = 1'b0;
    assign calib_done = 1'b0;
`endif

endmodule

// File: tb/tb_clkdiv_rst_seq.sv
// Directed bench for clkdiv_rst_seq at default parameters (16/8/2).
// Calibration scenarios run when CLKDIV_RST_SEQ_CALIB_EN is defined; otherwise
// the tied-off calibration behaviour is exercised instead.
module tb_clkdiv_rst_seq;

    logic hclkin = 1'b0;
    logic reset;
    logic pll_lock;
    logic calib_req;
    logic div_resetn, div_calib, div_ready, calib_busy, calib_done;

    int errors = 0;
    int checks = 0;

    clkdiv_rst_seq dut (
        .hclkin     (hclkin),
        .reset      (reset),
        .pll_lock   (pll_lock),
        .calib_req  (calib_req),
        .div_resetn (div_resetn),
        .div_calib  (div_calib),
        .div_ready  (div_ready),
        .calib_busy (calib_busy),
        .calib_done (calib_done)
    );

    always #5 hclkin = ~hclkin;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge hclkin);
        #1;
    endtask

    // Reset with lock present and bring the sequencer to its first READY cycle.
    task automatic bring_up();
        reset = 1'b1; pll_lock = 1'b1; calib_req = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(26);
    endtask

    task automatic test_reset();
        reset = 1'b1; pll_lock = 1'b1; calib_req = 1'b1;
        tick(3);
        checks++; if (div_resetn !== 1'b0) begin errors++;
            $display("FAIL reset_resetn: got %b expected 0", div_resetn); end
        checks++; if (div_calib !== 1'b0) begin errors++;
            $display("FAIL reset_calib: got %b expected 0", div_calib); end
        checks++; if (div_ready !== 1'b0) begin errors++;
            $display("FAIL reset_ready: got %b expected 0", div_ready); end
        checks++; if (calib_busy !== 1'b0) begin errors++;
            $display("FAIL reset_busy: got %b expected 0", calib_busy); end
        checks++; if (calib_done !== 1'b0) begin errors++;
            $display("FAIL reset_done: got %b expected 0", calib_done); end
        calib_req = 1'b0;
    endtask

    // Lock present at reset release: resetn rises at edge 18, ready at edge 26.
    task automatic test_lock_sequence();
        logic exp_rn, exp_rdy;
        reset = 1'b1; pll_lock = 1'b1; calib_req = 1'b0;
        tick(1);
        reset = 1'b0;
        for (int k = 1; k <= 27; k++) begin
            tick(1);
            exp_rn  = (k >= 18);
            exp_rdy = (k >= 26);
            checks++; if (div_resetn !== exp_rn) begin errors++;
                $display("FAIL lockseq_resetn k=%0d: got %b expected %b", k, div_resetn, exp_rn); end
            checks++; if (div_ready !== exp_rdy) begin errors++;
                $display("FAIL lockseq_ready k=%0d: got %b expected %b", k, div_ready, exp_rdy); end
        end
    endtask

    // No lock for 40 cycles, then the normal 18/26 sequence from the lock edge.
    task automatic test_late_lock();
        logic exp_rn, exp_rdy;
        reset = 1'b1; pll_lock = 1'b0; calib_req = 1'b0;
        tick(1);
        reset = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick(1);
            checks++; if (div_resetn !== 1'b0) begin errors++;
                $display("FAIL nolock_resetn k=%0d: got %b expected 0", k, div_resetn); end
        end
        pll_lock = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick(1);
            exp_rn  = (k >= 18);
            exp_rdy = (k >= 26);
            checks++; if (div_resetn !== exp_rn) begin errors++;
                $display("FAIL latelock_resetn k=%0d: got %b expected %b", k, div_resetn, exp_rn); end
            checks++; if (div_ready !== exp_rdy) begin errors++;
                $display("FAIL latelock_ready k=%0d: got %b expected %b", k, div_ready, exp_rdy); end
        end
    endtask

    // A lock glitch mid-HOLD must restart the count from zero.
    task automatic test_hold_restart();
        logic exp_rn, exp_rdy;
        reset = 1'b1; pll_lock = 1'b1; calib_req = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(10);
        pll_lock = 1'b0;
        tick(3);
        pll_lock = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick(1);
            exp_rn  = (k >= 18);
            exp_rdy = (k >= 26);
            checks++; if (div_resetn !== exp_rn) begin errors++;
                $display("FAIL restart_resetn k=%0d: got %b expected %b", k, div_resetn, exp_rn); end
            checks++; if (div_ready !== exp_rdy) begin errors++;
                $display("FAIL restart_ready k=%0d: got %b expected %b", k, div_ready, exp_rdy); end
        end
    endtask

    // calib_req during SETTLE only is ignored; READY arrives on time and stays.
    task automatic test_settle_req();
        reset = 1'b1; pll_lock = 1'b1; calib_req = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(20);
        calib_req = 1'b1;
        tick(5);
        calib_req = 1'b0;
        for (int k = 26; k <= 31; k++) begin
            tick(1);
            checks++; if (div_ready !== 1'b1) begin errors++;
                $display("FAIL settlereq_ready e=%0d: got %b expected 1", k, div_ready); end
            checks++; if (div_calib !== 1'b0 || calib_busy !== 1'b0) begin errors++;
                $display("FAIL settlereq_calib e=%0d: got calib=%b busy=%b expected 0 0",
                         k, div_calib, calib_busy); end
        end
    endtask

`ifdef CLKDIV_RST_SEQ_CALIB_EN
    // One-cycle request: calib 2 cycles, ready low 10, done with ready.
    task automatic test_calib();
        logic exp_cal, exp_rdy, exp_busy, exp_done;
        bring_up();
        calib_req = 1'b1;
        tick(1);
        calib_req = 1'b0;
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) tick(1);
            exp_cal  = (k < 2);
            exp_rdy  = (k >= 10);
            exp_busy = (k < 10);
            exp_done = (k == 10);
            checks++; if (div_calib !== exp_cal) begin errors++;
                $display("FAIL calib_pin k=%0d: got %b expected %b", k, div_calib, exp_cal); end
            checks++; if (div_ready !== exp_rdy) begin errors++;
                $display("FAIL calib_ready k=%0d: got %b expected %b", k, div_ready, exp_rdy); end
            checks++; if (calib_busy !== exp_busy) begin errors++;
                $display("FAIL calib_busy k=%0d: got %b expected %b", k, calib_busy, exp_busy); end
            checks++; if (calib_done !== exp_done) begin errors++;
                $display("FAIL calib_done k=%0d: got %b expected %b", k, calib_done, exp_done); end
        end
    endtask

    // Held request retriggers on the first READY cycle after completion.
    task automatic test_back_to_back();
        bring_up();
        calib_req = 1'b1;
        tick(11);
        checks++; if (div_ready !== 1'b1 || calib_done !== 1'b1) begin errors++;
            $display("FAIL b2b_first_done: got ready=%b done=%b expected 1 1",
                     div_ready, calib_done); end
        tick(1);
        checks++; if (div_ready !== 1'b0 || div_calib !== 1'b1 || calib_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_retrigger: got ready=%b calib=%b busy=%b expected 0 1 1",
                     div_ready, div_calib, calib_busy); end
        checks++; if (calib_done !== 1'b0) begin errors++;
            $display("FAIL b2b_done_pulse: got %b expected 0", calib_done); end
        calib_req = 1'b0;
        tick(10);
        checks++; if (div_ready !== 1'b1 || calib_done !== 1'b1) begin errors++;
            $display("FAIL b2b_second_done: got ready=%b done=%b expected 1 1",
                     div_ready, calib_done); end
    endtask

    // Lock lost while calibrating: back to HOLD, no done, full re-sequence.
    task automatic test_calib_lock_loss();
        logic exp_rn, exp_rdy;
        bring_up();
        calib_req = 1'b1;
        tick(1);
        calib_req = 1'b0;
        pll_lock  = 1'b0;
        tick(1);
        checks++; if (div_calib !== 1'b1 || div_resetn !== 1'b1) begin errors++;
            $display("FAIL loss_r1: got calib=%b resetn=%b expected 1 1", div_calib, div_resetn); end
        tick(1);
        checks++; if (div_calib !== 1'b0) begin errors++;
            $display("FAIL loss_r2_calib: got %b expected 0", div_calib); end
        tick(1);
        checks++; if (div_resetn !== 1'b0 || calib_busy !== 1'b0 || div_ready !== 1'b0) begin
            errors++;
            $display("FAIL loss_r3: got resetn=%b busy=%b ready=%b expected 0 0 0",
                     div_resetn, calib_busy, div_ready); end
        for (int k = 0; k < 5; k++) begin
            checks++; if (calib_done !== 1'b0 || div_resetn !== 1'b0) begin errors++;
                $display("FAIL loss_hold k=%0d: got done=%b resetn=%b expected 0 0",
                         k, calib_done, div_resetn); end
            tick(1);
        end
        pll_lock = 1'b1;
        for (int k = 1; k <= 26; k++) begin
            tick(1);
            exp_rn  = (k >= 18);
            exp_rdy = (k >= 26);
            checks++; if (div_resetn !== exp_rn || calib_done !== 1'b0) begin errors++;
                $display("FAIL relock_resetn k=%0d: got resetn=%b done=%b expected %b 0",
                         k, div_resetn, calib_done, exp_rn); end
            checks++; if (div_ready !== exp_rdy) begin errors++;
                $display("FAIL relock_ready k=%0d: got %b expected %b", k, div_ready, exp_rdy); end
        end
    endtask

    // Reset mid-calibration clears everything at once and never yields done.
    task automatic test_reset_mid_calib();
        logic exp_rn, exp_rdy;
        bring_up();
        calib_req = 1'b1;
        tick(1);
        calib_req = 1'b0;
        tick(3);
        reset = 1'b1;
        #1;
        checks++; if ({div_resetn, div_calib, div_ready, calib_busy, calib_done} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got %b expected 00000",
                     {div_resetn, div_calib, div_ready, calib_busy, calib_done}); end
        tick(2);
        reset = 1'b0;
        for (int k = 1; k <= 26; k++) begin
            tick(1);
            exp_rn  = (k >= 18);
            exp_rdy = (k >= 26);
            checks++; if (div_resetn !== exp_rn || calib_done !== 1'b0) begin errors++;
                $display("FAIL midreset_resetn k=%0d: got resetn=%b done=%b expected %b 0",
                         k, div_resetn, calib_done, exp_rn); end
            checks++; if (div_ready !== exp_rdy) begin errors++;
                $display("FAIL midreset_ready k=%0d: got %b expected %b", k, div_ready, exp_rdy); end
        end
    endtask
`else
    // Calibration disabled: a held request changes nothing.
    task automatic test_no_calib();
        bring_up();
        calib_req = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            checks++; if (div_calib !== 1'b0 || calib_busy !== 1'b0 || calib_done !== 1'b0) begin
                errors++;
                $display("FAIL nocalib_outs k=%0d: got calib=%b busy=%b done=%b expected 0 0 0",
                         k, div_calib, calib_busy, calib_done); end
            checks++; if (div_ready !== 1'b1) begin errors++;
                $display("FAIL nocalib_ready k=%0d: got %b expected 1", k, div_ready); end
        end
        calib_req = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b1; pll_lock = 1'b0; calib_req = 1'b0;
        test_reset();
        test_lock_sequence();
        test_late_lock();
        test_hold_restart();
        test_settle_req();
`ifdef CLKDIV_RST_SEQ_CALIB_EN
        test_calib();
        test_back_to_back();
        test_calib_lock_loss();
        test_reset_mid_calib();
`else
        test_no_calib();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
